// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the LEGv8 datapath. Holds the fetch PC, requests one 32-bit
// instruction word at a time from instruction memory over a req/ack
// handshake, and presents the fetched word to decode. When decode consumes
// the word, the next PC is chosen from a register target (BR), a PC-relative
// branch (oPC + iImmExt) or sequential PC+4. A misaligned next PC stops
// fetching and raises a sticky fault that only reset clears.
//
// Ports:
//   iCLK          rising-edge clock
//   iRST          asynchronous active-low reset
//   oIMemReq      fetch request to instruction memory
//   oIMemAddr     byte address of the requested word (always the fetch PC)
//   iIMemAck      memory returns iIMemData this cycle
//   iIMemData     instruction word, valid with iIMemAck
//   oInstr        registered instruction presented to decode
//   oPC           address of oInstr
//   oInstrValid   oInstr/oPC hold a fetched, unconsumed instruction
//   iStall        decode/execute not ready; hold the current instruction
//   iImmExt       sign-extended, pre-shifted branch offset (bytes)
//   iBranchTaken  PC-relative branch taken for oInstr
//   iBrReg        register-indirect branch (BR) for oInstr
//   iRegTarget    BR target address
//   oFault        sticky misaligned-target flag
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMemReq,
    output logic [63:0] oIMemAddr,
    input  logic        iIMemAck,
    input  logic [31:0] iIMemData,
    output logic [31:0] oInstr,
    output logic [63:0] oPC,
    output logic        oInstrValid,
    input  logic        iStall,
    input  logic [63:0] iImmExt,
    input  logic        iBranchTaken,
    input  logic        iBrReg,
    input  logic [63:0] iRegTarget,
    output logic        oFault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] fetch_pc;
    logic [63:0] fetch_pc_next;
    logic [31:0] instr_next;
    logic [63:0] pc_next;
    logic        fault_next;
    logic [63:0] target_pc;

    // Next-PC selection for the instruction currently held in oInstr.
    // BR wins over a PC-relative branch; both additions wrap modulo 2^64.
    always_comb begin
        if (iBrReg) begin
            target_pc = iRegTarget;
        end else if (iBranchTaken) begin
            target_pc = oPC + iImmExt;
        end else begin
            target_pc = oPC + 64'd4;
        end
    end

    // Next-state and next-register logic. Everything holds by default, so a
    // stalled VALID cycle or the FAULT state simply keeps all registers.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        instr_next    = oInstr;
        pc_next       = oPC;
        fault_next    = oFault;
        case (state)
            FETCH: begin
                if (iIMemAck) begin
                    instr_next = iIMemData;
                    pc_next    = fetch_pc;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (!iStall) begin
                    // The misaligned target is still latched into the fetch
                    // PC so it remains visible on oIMemAddr for debug.
                    fetch_pc_next = target_pc;
                    if (target_pc[1:0] == 2'b00) begin
                        state_next = FETCH;
                    end else begin
                        fault_next = 1'b1;
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            oInstr   <= 32'h0;
            oPC      <= RESET_PC;
            oFault   <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            oInstr   <= instr_next;
            oPC      <= pc_next;
            oFault   <= fault_next;
        end
    end

    // Reset already parks the state in FETCH, so the request is gated by the
    // reset level itself to keep it low for the whole time reset is held.
    assign oIMemReq    = iRST && (state == FETCH);
    assign oIMemAddr   = fetch_pc;
    assign oInstrValid = (state == VALID);

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Scoreboard bench for instruction_fetch. The stimulus process queues the
// fetch addresses it expects; a memory model checks each request against
// that queue, answers after a programmable number of wait cycles and pushes
// the expected (instruction, PC) pair; a monitor pops the pair whenever a new
// instruction becomes valid and compares it with oInstr/oPC.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        iCLK;
    logic        iRST;
    logic        oIMemReq;
    logic [63:0] oIMemAddr;
    logic        iIMemAck;
    logic [31:0] iIMemData;
    logic [31:0] oInstr;
    logic [63:0] oPC;
    logic        oInstrValid;
    logic        iStall;
    logic [63:0] iImmExt;
    logic        iBranchTaken;
    logic        iBrReg;
    logic [63:0] iRegTarget;
    logic        oFault;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } sb_entry_t;

    logic [63:0] exp_addr_q[$];
    sb_entry_t   sb_q[$];

    int checks    = 0;
    int failures  = 0;
    int cycle     = 0;
    int mem_wait  = 0;
    bit mem_on    = 0;

    instruction_fetch #(
        .RESET_PC(64'h0)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .oIMemReq    (oIMemReq),
        .oIMemAddr   (oIMemAddr),
        .iIMemAck    (iIMemAck),
        .iIMemData   (iIMemData),
        .oInstr      (oInstr),
        .oPC         (oPC),
        .oInstrValid (oInstrValid),
        .iStall      (iStall),
        .iImmExt     (iImmExt),
        .iBranchTaken(iBranchTaken),
        .iBrReg      (iBrReg),
        .iRegTarget  (iRegTarget),
        .oFault      (oFault)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        forever begin
            @(posedge iCLK);
            cycle++;
        end
    end

    // Hard stop in case some unbounded path sneaks in.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    // ADDI-style word whose immediate/rd fields encode the address, so each
    // fetched location returns a distinguishable instruction.
    function automatic logic [31:0] instrWord(input logic [63:0] a);
        return 32'h9100_0000 | {8'h00, a[13:2], 10'h000} | {27'h0, a[6:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Memory model: checks each new request against the expected address
    // queue, checks address stability during wait cycles, then acks.
    initial begin : memory_model
        bit          in_req;
        bit          acked_now;
        int          wait_cnt;
        logic [63:0] cur_req;
        sb_entry_t   e;
        in_req    = 0;
        wait_cnt  = 0;
        cur_req   = 64'h0;
        iIMemAck  = 1'b0;
        iIMemData = 32'h0;
        forever begin
            @(negedge iCLK);
            acked_now = 0;
            if (mem_on && oIMemReq) begin
                if (!in_req) begin
                    in_req   = 1;
                    wait_cnt = 0;
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("req_expected", 64'(exp_addr_q.size()), 64'd1);
                        cur_req = oIMemAddr;
                    end else begin
                        cur_req = exp_addr_q.pop_front();
                        checkOutput("req_addr", oIMemAddr, cur_req);
                    end
                end else begin
                    checkOutput("addr_stable", oIMemAddr, cur_req);
                end
                if (wait_cnt >= mem_wait) begin
                    iIMemAck  = 1'b1;
                    iIMemData = instrWord(cur_req);
                    e.instr   = instrWord(cur_req);
                    e.pc      = cur_req;
                    sb_q.push_back(e);
                    in_req    = 0;
                    acked_now = 1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_req = 0;
            end
            @(posedge iCLK);
            #1;
            if (acked_now) begin
                iIMemAck  = 1'b0;
                iIMemData = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: every rising oInstrValid must match the oldest scoreboard entry.
    initial begin : monitor
        bit        prev_valid;
        sb_entry_t e;
        prev_valid = 0;
        forever begin
            @(negedge iCLK);
            if (oInstrValid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_entry_present", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("mon_instr", 64'(oInstr), 64'(e.instr));
                    checkOutput("mon_pc", oPC, e.pc);
                end
            end
            prev_valid = oInstrValid;
        end
    end

    task automatic waitValid(output int found);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            if (oInstrValid) begin
                found = 1;
                break;
            end
        end
        if (found == 0) checkOutput("valid_timeout", 64'd0, 64'd1);
    endtask

    // Waits for the instruction at cur_pc, stalls it, then consumes it with
    // the given branch inputs and checks the cycle after consumption.
    task automatic applyStimulus(input logic [63:0] cur_pc, input int stall_cycles,
                                 input logic br_reg, input logic br_taken,
                                 input logic [63:0] imm, input logic [63:0] tgt,
                                 input logic [63:0] exp_next, input logic exp_fault,
                                 input int next_wait, output int valid_cycle);
        int found;
        waitValid(found);
        valid_cycle = cycle;
        checkOutput("valid_pc", oPC, cur_pc);
        for (int i = 0; i < stall_cycles; i++) begin
            @(negedge iCLK);
            checkOutput("stall_valid", 64'(oInstrValid), 64'd1);
            checkOutput("stall_pc", oPC, cur_pc);
            checkOutput("stall_instr", 64'(oInstr), 64'(instrWord(cur_pc)));
            checkOutput("stall_req", 64'(oIMemReq), 64'd0);
        end
        mem_wait     = next_wait;
        iBrReg       = br_reg;
        iBranchTaken = br_taken;
        iImmExt      = imm;
        iRegTarget   = tgt;
        iStall       = 1'b0;
        @(posedge iCLK);
        #1;
        iStall       = 1'b1;
        iBrReg       = 1'b0;
        iBranchTaken = 1'b0;
        iImmExt      = 64'h5555_5555_5555_5555;
        iRegTarget   = 64'hAAAA_AAAA_AAAA_AAA8;
        if (!exp_fault) exp_addr_q.push_back(exp_next);
        @(negedge iCLK);
        checkOutput("post_valid", 64'(oInstrValid), 64'd0);
        checkOutput("post_fault", 64'(oFault), 64'(exp_fault));
        checkOutput("post_req", 64'(oIMemReq), 64'(!exp_fault));
        checkOutput("post_addr", oIMemAddr, exp_next);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 64'(oIMemReq), 64'd0);
        checkOutput({tag, "_addr"}, oIMemAddr, 64'h0);
        checkOutput({tag, "_instr"}, 64'(oInstr), 64'd0);
        checkOutput({tag, "_pc"}, oPC, 64'h0);
        checkOutput({tag, "_valid"}, 64'(oInstrValid), 64'd0);
        checkOutput({tag, "_fault"}, 64'(oFault), 64'd0);
    endtask

    // Directed sequence.
    initial begin : stimulus
        int v0, v1, v2, v3, found;
        iRST         = 1'b0;
        iStall       = 1'b1;
        iBrReg       = 1'b0;
        iBranchTaken = 1'b0;
        iImmExt      = 64'h0;
        iRegTarget   = 64'h0;

        // Reset held: everything zero, an ack during reset is dropped.
        repeat (2) @(negedge iCLK);
        checkResetState("rst");
        iIMemAck  = 1'b1;
        iIMemData = 32'h1234_5678;
        @(posedge iCLK);
        #1;
        iIMemAck  = 1'b0;
        @(negedge iCLK);
        checkResetState("rst_ack");

        exp_addr_q.push_back(64'h0);
        mem_on   = 1;
        mem_wait = 0;
        @(posedge iCLK);
        #2;
        iRST = 1'b1;

        // Sequential zero-wait fetch: one instruction every two cycles.
        applyStimulus(64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h4, 0, 0, v0);
        applyStimulus(64'h4, 0, 0, 0, 64'h0, 64'h0, 64'h8, 0, 0, v1);
        applyStimulus(64'h8, 0, 0, 0, 64'h0, 64'h0, 64'hC, 0, 0, v2);
        checkOutput("period_1", 64'(v1 - v0), 64'd2);
        checkOutput("period_2", 64'(v2 - v1), 64'd2);

        // Three wait cycles on the fetch of 0x10, then a four-cycle stall.
        applyStimulus(64'hC, 0, 0, 0, 64'h0, 64'h0, 64'h10, 0, 3, v3);
        applyStimulus(64'h10, 4, 0, 0, 64'h0, 64'h0, 64'h14, 0, 0, v0);

        // PC-relative branches from 0x40, backward and forward.
        applyStimulus(64'h14, 0, 1, 0, 64'h0, 64'h40, 64'h40, 0, 0, v0);
        applyStimulus(64'h40, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h30, 0, 0, v0);
        applyStimulus(64'h30, 0, 1, 0, 64'h0, 64'h40, 64'h40, 0, 0, v0);
        applyStimulus(64'h40, 0, 0, 1, 64'h100, 64'h0, 64'h140, 0, 0, v0);

        // BR beats a simultaneous taken branch; PC+4 wraps to zero.
        applyStimulus(64'h140, 0, 1, 1, 64'h8, 64'h2000, 64'h2000, 0, 0, v0);
        applyStimulus(64'h2000, 0, 1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC,
                      64'hFFFF_FFFF_FFFF_FFFC, 0, 0, v0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 0, v0);

        // Misaligned BR target traps until reset.
        applyStimulus(64'h0, 0, 1, 0, 64'h0, 64'h1002, 64'h1002, 1, 0, v0);
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            checkOutput("fault_sticky", 64'(oFault), 64'd1);
            checkOutput("fault_req", 64'(oIMemReq), 64'd0);
            checkOutput("fault_valid", 64'(oInstrValid), 64'd0);
            checkOutput("fault_pc", oPC, 64'h0);
            checkOutput("fault_instr", 64'(oInstr), 64'(instrWord(64'h0)));
        end
        #2;
        iRST = 1'b0;
        #1;
        checkResetState("fault_clr");
        exp_addr_q.push_back(64'h0);
        @(posedge iCLK);
        #2;
        iRST = 1'b1;

        // Park a never-acked request at 0x80, then reset between edges.
        applyStimulus(64'h0, 0, 1, 0, 64'h0, 64'h80, 64'h80, 0, 1000, v0);
        repeat (2) @(negedge iCLK);
        checkOutput("pre_async_req", 64'(oIMemReq), 64'd1);
        #3;
        mem_on = 0;
        iRST   = 1'b0;
        #1;
        checkOutput("async_req", 64'(oIMemReq), 64'd0);
        checkOutput("async_addr", oIMemAddr, 64'h0);
        @(negedge iCLK);
        iIMemAck  = 1'b1;
        iIMemData = 32'hCAFE_F00D;
        @(posedge iCLK);
        #1;
        iIMemAck  = 1'b0;
        @(negedge iCLK);
        checkResetState("late_ack");

        mem_wait = 0;
        mem_on   = 1;
        exp_addr_q.push_back(64'h0);
        @(posedge iCLK);
        #2;
        iRST = 1'b1;
        applyStimulus(64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h4, 0, 0, v0);
        waitValid(found);
        checkOutput("final_pc", oPC, 64'h4);
        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        checkOutput("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
